dmem_mmio: RTL and testbench

- Data-side memory subsystem sitting directly downstream of the single-cycle core's load/store path.
- Inputs: the core's store enable, the ALU result as byte address, and store data. It returns load data combinationally in the same cycle, as a single-cycle core requires.
- Contains a byte-addressable word RAM with sub-word load/store, plus a small memory-mapped register block: LED register, 64-bit free-running cycle counter, and a tohost/done register for simulation end.
- Sequential state: RAM writes, MMIO registers, counter, sticky error flag.

---
 rtl/dmem_mmio_if.sv | 13 +
 rtl/dmem_mmio.sv | 116 +++++++++++
 tb/tb_dmem_mmio.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_if.sv
// rtl/dmem_mmio_if.sv - core load/store bus into the data memory subsystem
interface dmem_mmio_if #(
  parameter int XLEN = 32
);
  logic            MemWrite;
  logic [2:0]      funct3;
  logic [XLEN-1:0] ALUResult;
  logic [XLEN-1:0] WriteData;
  logic [XLEN-1:0] ReadData;

  modport master (output MemWrite, funct3, ALUResult, WriteData, input ReadData);
  modport slave  (input MemWrite, funct3, ALUResult, WriteData, output ReadData);
endinterface

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - word RAM with sub-word access plus LED/cycle/tohost MMIO block
// Loads are combinational so a single-cycle core sees data in the same cycle.
module dmem_mmio #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 64,
  parameter logic [XLEN-1:0] MMIO_BASE = 32'hF000_0000,
  parameter string           MEMFILE   = ""
) (
  input  logic            clk,
  input  logic            reset,
  dmem_mmio_if.slave      bus,
  output logic [7:0]      leds,
  output logic            done,
  output logic [XLEN-1:0] tohost,
  output logic            misaligned
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] ram [DEPTH];
  logic [63:0]     cycle;

  logic            we;
  logic [2:0]      f3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   widx;
  logic            is_ram;
  logic            is_mmio;
  logic            mis;
  logic [XLEN-1:0] word;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [XLEN-1:0] rdata;

  assign we    = bus.MemWrite;
  assign f3    = bus.funct3;
  assign addr  = bus.ALUResult;
  assign wdata = bus.WriteData;
  assign widx  = addr[AW+1:2];

  // LHU (101) is only a half access on the load side; as a store it is a no-op.
  always_comb begin
    is_ram  = addr < XLEN'(DEPTH * 4);
    is_mmio = addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
    mis     = 1'b0;
    if (f3 == 3'b010)
      mis = addr[1:0] != 2'b00;
    else if (f3 == 3'b001 || (!we && f3 == 3'b101))
      mis = addr[0];
  end

  always_comb begin
    word = '0;
    if (is_ram) begin
      word = ram[widx];
    end else if (is_mmio) begin
      case (addr[3:2])
        2'd0:    word = XLEN'(leds);
        2'd1:    word = XLEN'(cycle[31:0]);
        2'd2:    word = XLEN'(cycle[63:32]);
        default: word = tohost;
      endcase
    end
    rbyte = word[{addr[1:0], 3'b000} +: 8];
    rhalf = word[{addr[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  rdata = {{(XLEN-8){rbyte[7]}}, rbyte};
      3'b001:  rdata = {{(XLEN-16){rhalf[15]}}, rhalf};
      3'b100:  rdata = {{(XLEN-8){1'b0}}, rbyte};
      3'b101:  rdata = {{(XLEN-16){1'b0}}, rhalf};
      default: rdata = word;
    endcase
    if (mis)
      rdata = '0;
  end

  assign bus.ReadData = rdata;

  // RAM is never cleared; reset only blocks a store in flight.
  always_ff @(posedge clk) begin
    if (!reset && we && is_ram && !mis) begin
      case (f3)
        3'b000:  ram[widx][{addr[1:0], 3'b000} +: 8]  <= wdata[7:0];
        3'b001:  ram[widx][{addr[1], 4'b0000} +: 16] <= wdata[15:0];
        3'b010:  ram[widx] <= wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds       <= '0;
      done       <= 1'b0;
      tohost     <= '0;
      misaligned <= 1'b0;
      cycle      <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (mis)
        misaligned <= 1'b1;
      if (we && is_mmio && f3 == 3'b010 && !mis) begin
        case (addr[3:2])
          2'd0: leds <= wdata[7:0];
          2'd3: begin
            tohost <= wdata;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - directed and randomized checks of dmem_mmio against a byte-level model
module tb_dmem_mmio;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 64;
  localparam int          BYTES = DEPTH * 4;
  localparam logic [31:0] BASE  = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  leds;
  logic        done;
  logic [31:0] tohost;
  logic        misaligned;

  always #5 clk = ~clk;

  dmem_mmio_if #(.XLEN(XLEN)) bus ();

  dmem_mmio #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MMIO_BASE(BASE), .MEMFILE("")
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .leds(leds), .done(done),
    .tohost(tohost), .misaligned(misaligned)
  );

  int tests = 0;
  int fails = 0;

  bit [7:0]        mm [BYTES];
  bit [7:0]        m_leds;
  bit              m_done;
  bit [31:0]       m_tohost;
  bit              m_mis;
  longint unsigned m_cycle;

  bit        cur_we;
  bit [2:0]  cur_f3;
  bit [31:0] cur_a;
  bit [31:0] cur_wd;
  bit        cur_rst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit bad_align(bit [2:0] f3, bit [31:0] a, bit we);
    bit half, full;
    full = (f3 == 3'd2);
    half = (f3 == 3'd1) || (!we && f3 == 3'd5);
    return (half && (a % 2 != 0)) || (full && (a % 4 != 0));
  endfunction

  function automatic bit in_mmio(bit [31:0] a);
    return (a >> 4) == (BASE >> 4);
  endfunction

  function automatic bit [31:0] m_word(bit [31:0] a);
    int b;
    if (a < BYTES) begin
      b = int'(a) - int'(a % 4);
      return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    end
    if (in_mmio(a)) begin
      case ((a % 16) / 4)
        0:       return {24'd0, m_leds};
        1:       return m_cycle[31:0];
        2:       return m_cycle[63:32];
        default: return m_tohost;
      endcase
    end
    return 32'd0;
  endfunction

  function automatic bit [31:0] m_load(bit [2:0] f3, bit [31:0] a);
    bit [31:0] w;
    bit [7:0]  b;
    bit [15:0] h;
    if (bad_align(f3, a, 1'b0))
      return 32'd0;
    w = m_word(a);
    b = 8'(w >> (8 * (a % 4)));
    h = 16'(w >> (16 * ((a / 2) % 2)));
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic m_edge();
    if (cur_rst) begin
      m_leds = 0; m_done = 0; m_tohost = 0; m_mis = 0; m_cycle = 0;
      return;
    end
    m_cycle++;
    if (bad_align(cur_f3, cur_a, cur_we)) begin
      m_mis = 1;
    end else if (cur_we) begin
      if (cur_a < BYTES) begin
        if (cur_f3 == 3'd0) mm[cur_a] = cur_wd[7:0];
        if (cur_f3 == 3'd1 || cur_f3 == 3'd2) begin
          mm[cur_a] = cur_wd[7:0]; mm[cur_a+1] = cur_wd[15:8];
        end
        if (cur_f3 == 3'd2) begin
          mm[cur_a+2] = cur_wd[23:16]; mm[cur_a+3] = cur_wd[31:24];
        end
      end else if (in_mmio(cur_a) && cur_f3 == 3'd2) begin
        if (cur_a % 16 == 0) m_leds = cur_wd[7:0];
        if (cur_a % 16 == 12) begin
          m_tohost = cur_wd; m_done = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit we, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit rst);
    cur_we = we; cur_f3 = f3; cur_a = a; cur_wd = wd; cur_rst = rst;
    bus.MemWrite = we; bus.funct3 = f3; bus.ALUResult = a; bus.WriteData = wd;
    reset = rst;
    #1;
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
    chk("leds", 64'(leds), 64'(m_leds));
    chk("done", 64'(done), 64'(m_done));
    chk("tohost", 64'(tohost), 64'(m_tohost));
    chk("misaligned", 64'(misaligned), 64'(m_mis));
  endtask

  task automatic step(input bit we, input bit [2:0] f3, input bit [31:0] a,
                      input bit [31:0] wd, input bit rst);
    drive(we, f3, a, wd, rst);
    if (!we && !rst)
      chk("model_load", 64'(bus.ReadData), 64'(m_load(f3, a)));
    tick();
  endtask

  task automatic ldc(input string tag, input bit [2:0] f3, input bit [31:0] a,
                     input bit [31:0] exp);
    drive(1'b0, f3, a, 32'd0, 1'b0);
    chk(tag, 64'(bus.ReadData), 64'(exp));
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 3'd2, 32'h0000_1000, 32'd0, 1'b0);
  endtask

  initial begin
    bit [31:0] w0;
    bit [31:0] c0;
    bit [31:0] a;

    drive(1'b0, 3'd2, 32'h0000_1000, 32'd0, 1'b1);
    tick();
    tick();
    chk("rst_leds", 64'(leds), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tohost", 64'(tohost), 64'd0);
    chk("rst_mis", 64'(misaligned), 64'd0);

    idle(10);
    ldc("cycle_lo_10", 3'd2, BASE + 4, 32'd10);
    ldc("cycle_hi_0", 3'd2, BASE + 8, 32'd0);

    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0);

    step(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0);
    ldc("lw_10", 3'd2, 32'h10, 32'hDEAD_BEEF);
    ldc("lb_13", 3'd0, 32'h13, 32'hFFFF_FFDE);
    ldc("lbu_13", 3'd4, 32'h13, 32'h0000_00DE);
    ldc("lh_12", 3'd1, 32'h12, 32'hFFFF_DEAD);
    ldc("lhu_10", 3'd5, 32'h10, 32'h0000_BEEF);

    step(1'b1, 3'd2, 32'h20, 32'h1122_3344, 1'b0);
    step(1'b1, 3'd0, 32'h21, 32'h0000_00AA, 1'b0);
    step(1'b1, 3'd1, 32'h22, 32'h0000_5566, 1'b0);
    ldc("lw_20_merge", 3'd2, 32'h20, 32'h5566_AA44);

    step(1'b1, 3'd2, BASE + 12, 32'd5, 1'b0);
    chk("done_set", 64'(done), 64'd1);
    chk("tohost_5", 64'(tohost), 64'd5);
    step(1'b1, 3'd2, BASE, 32'h0000_00A5, 1'b0);
    chk("leds_a5", 64'(leds), 64'hA5);
    step(1'b1, 3'd0, BASE, 32'h0000_0033, 1'b0);
    chk("leds_sb_ignored", 64'(leds), 64'hA5);
    step(1'b1, 3'd2, BASE + 4, 32'hFFFF_FFFF, 1'b0);
    c0 = m_cycle[31:0];
    ldc("cycle_ro", 3'd2, BASE + 4, c0);
    step(1'b1, 3'd2, BASE + 12, 32'd7, 1'b0);
    chk("done_sticky", 64'(done), 64'd1);
    chk("tohost_7", 64'(tohost), 64'd7);

    chk("mis_clear", 64'(misaligned), 64'd0);
    step(1'b1, 3'd2, 32'h22, 32'h1234_5678, 1'b0);
    chk("mis_set", 64'(misaligned), 64'd1);
    idle(5);
    chk("mis_hold", 64'(misaligned), 64'd1);
    ldc("mis_st_suppr", 3'd2, 32'h20, 32'h5566_AA44);
    ldc("lh_21_zero", 3'd1, 32'h21, 32'd0);

    w0 = m_word(32'h0);
    step(1'b1, 3'd2, BYTES, 32'hCAFE_F00D, 1'b0);
    ldc("unmapped_rd", 3'd2, BYTES, 32'd0);
    ldc("unmapped_wr", 3'd2, 32'h0, w0);

    step(1'b1, 3'd2, 32'h0, 32'h1357_9BDF, 1'b1);
    chk("mis_rst", 64'(misaligned), 64'd0);
    chk("done_rst", 64'(done), 64'd0);
    ldc("cycle_after_rst", 3'd2, BASE + 4, 32'd0);
    ldc("rst_wr_suppr", 3'd2, 32'h0, w0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        7, 8:    a = BASE + $urandom_range(0, 15);
        9:       a = $urandom_range(BYTES, 4095);
        default: a = $urandom_range(0, BYTES - 1);
      endcase
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
           ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
